mem_stage: RTL

Parametrised memory stage between the EX/MEM and MEM/WB pipeline registers. It extends the fixed single-cycle word stage with byte, halfword and word (optionally doubleword) accesses and little-endian lane steering. It adds a variable-latency RAM handshake with pipeline stall and a bus-timeout counter, plus a misalignment trap. Output is a registered MEM/WB bundle with a valid bit, so stalls appear downstream as bubbles.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 102 ++++++++++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory stage.
//   mem_size_e : access size encoding (BYTE, HALF, WORD, DWORD)
//   state_e    : handshake FSM states (IDLE, WAIT)
//   size_legal : DWORD is only legal on a 64-bit data path
//   align_ok   : natural alignment check on the low address bits
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    function automatic logic size_legal(input mem_size_e size, input int data_w);
        logic ok_s;
        case (size)
            DWORD:   ok_s = (data_w == 64) ? 1'b1 : 1'b0;
            default: ok_s = 1'b1;
        endcase
        return ok_s;
    endfunction

    function automatic logic align_ok(input logic [2:0] addr_low, input mem_size_e size);
        logic ok_s;
        case (size)
            BYTE:    ok_s = 1'b1;
            HALF:    ok_s = (addr_low[0]   == 1'b0);
            WORD:    ok_s = (addr_low[1:0] == 2'b00);
            DWORD:   ok_s = (addr_low[2:0] == 3'b000);
            default: ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane steering.
//   size, addr_off          : access size and byte offset inside the RAM word
//   is_write, unsigned_ld   : store vs load, zero- vs sign-extension
//   store_data              : right-aligned store data
//   word_in                 : raw RAM read word
//   store_lanes, be         : replicated store data and byte enables (all ones for loads)
//   load_data               : extracted and extended load result
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mem_size_e                      size,
    input  logic [$clog2(DATA_W/8)-1:0]    addr_off,
    input  logic                           is_write,
    input  logic                           unsigned_ld,
    input  logic [DATA_W-1:0]              store_data,
    input  logic [DATA_W-1:0]              word_in,
    output logic [DATA_W-1:0]              store_lanes,
    output logic [DATA_W/8-1:0]            be,
    output logic [DATA_W-1:0]              load_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] lanes_s;
    logic [NB-1:0]     be_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] mask_s;
    logic [DATA_W-1:0] load_s;
    logic              sign_s;
    int                off_i;
    int                span_i;
    int                nbits_i;

    // Replicate the store datum across every lane of its size so any offset sees it.
    always_comb begin
        lanes_s = '0;
        for (int i = 0; i < NB; i++) begin
            case (size)
                BYTE:    lanes_s[i*8 +: 8] = store_data[7:0];
                HALF:    lanes_s[i*8 +: 8] = store_data[(i%2)*8 +: 8];
                WORD:    lanes_s[i*8 +: 8] = store_data[(i%4)*8 +: 8];
                default: lanes_s[i*8 +: 8] = store_data[i*8 +: 8];
            endcase
        end
    end

    // Byte enables: 2^size ones starting at the byte offset for stores, all ones for loads.
    always_comb begin
        be_s   = '0;
        off_i  = int'(addr_off);
        span_i = 32'd1 << size;
        for (int i = 0; i < NB; i++) begin
            if (is_write) begin
                be_s[i] = ((i >= off_i) && (i < off_i + span_i)) ? 1'b1 : 1'b0;
            end else begin
                be_s[i] = 1'b1;
            end
        end
    end

    // Right-align the addressed lane, keep its width and sign- or zero-extend it.
    always_comb begin
        shifted_s = word_in >> {addr_off, 3'b000};
        nbits_i   = DATA_W;
        sign_s    = 1'b0;
        mask_s    = '0;
        case (size)
            BYTE: begin
                nbits_i = 8;
                sign_s  = shifted_s[7];
            end
            HALF: begin
                nbits_i = 16;
                sign_s  = shifted_s[15];
            end
            WORD: begin
                nbits_i = 32;
                sign_s  = shifted_s[31];
            end
            default: begin
                nbits_i = DATA_W;
                sign_s  = 1'b0;
            end
        endcase
        for (int b = 0; b < DATA_W; b++) begin
            mask_s[b] = (b < nbits_i) ? 1'b1 : 1'b0;
        end
        load_s = shifted_s & mask_s;
        if (!unsigned_ld && sign_s) begin
            load_s = load_s | ~mask_s;
        end else begin
            load_s = load_s;
        end
    end

    assign store_lanes = lanes_s;
    assign be          = be_s;
    assign load_data   = load_s;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage with variable-latency RAM handshake.
//   EX/MEM side : valid_in, wb_in, mem_read, mem_write, mem_size, mem_unsigned,
//                 address_in, write_data_in, write_register_in; stall back upstream
//   RAM side    : ram_req, ram_we, ram_be, ram_adr, ram_data out; ram_word, ram_ack in
//   MEM/WB side : valid_out, wb, read_data, address_wb, write_register_out,
//                 misaligned, bus_err (all registered; stalled edges load a bubble)
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int WB_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [WB_W-1:0]      wb_in,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_size,
    input  logic                 mem_unsigned,
    input  logic [ADDR_W-1:0]    address_in,
    input  logic [DATA_W-1:0]    write_data_in,
    input  logic [REG_W-1:0]     write_register_in,
    output logic                 stall,
    output logic                 ram_req,
    output logic                 ram_we,
    output logic [DATA_W/8-1:0]  ram_be,
    output logic [ADDR_W-1:0]    ram_adr,
    output logic [DATA_W-1:0]    ram_data,
    input  logic [DATA_W-1:0]    ram_word,
    input  logic                 ram_ack,
    output logic                 valid_out,
    output logic [WB_W-1:0]      wb,
    output logic [DATA_W-1:0]    read_data,
    output logic [ADDR_W-1:0]    address_wb,
    output logic [REG_W-1:0]     write_register_out,
    output logic                 misaligned,
    output logic                 bus_err
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_e              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    mem_size_e           size_s;
    logic                access_s, legal_s, go_s, fault_mis_s;
    logic                req_s, stall_s, done_s, timeout_s;
    logic [DATA_W-1:0]   load_s;

    logic                valid_out_r, misaligned_r, bus_err_r;
    logic [WB_W-1:0]     wb_r;
    logic [DATA_W-1:0]   read_data_r;
    logic [ADDR_W-1:0]   address_wb_r;
    logic [REG_W-1:0]    write_register_r;

    assign size_s      = mem_size_e'(mem_size);
    assign access_s    = valid_in & (mem_read | mem_write);
    assign legal_s     = size_legal(size_s, DATA_W) & align_ok(address_in[2:0], size_s);
    assign go_s        = access_s & legal_s;
    assign fault_mis_s = access_s & ~legal_s;

    mem_lane_align #(.DATA_W(DATA_W)) u_lane (
        .size        (size_s),
        .addr_off    (address_in[OFF_W-1:0]),
        .is_write    (mem_write),
        .unsigned_ld (mem_unsigned),
        .store_data  (write_data_in),
        .word_in     (ram_word),
        .store_lanes (ram_data),
        .be          (ram_be),
        .load_data   (load_s)
    );

    // Handshake FSM: request, stall, completion and timeout decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        req_s       = 1'b0;
        stall_s     = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    req_s = 1'b1;
                    if (ram_ack) begin
                        done_s = 1'b1;
                    end else begin
                        stall_s     = 1'b1;
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                req_s = 1'b1;
                // Ack is tested first so it wins over a simultaneous timeout.
                if (ram_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // FSM state and wait-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // MEM/WB slot: bubble on stalled edges, otherwise the completed instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out_r      <= 1'b0;
            wb_r             <= '0;
            read_data_r      <= '0;
            address_wb_r     <= '0;
            write_register_r <= '0;
            misaligned_r     <= 1'b0;
            bus_err_r        <= 1'b0;
        end else if (stall_s) begin
            valid_out_r      <= 1'b0;
            wb_r             <= '0;
            read_data_r      <= '0;
            address_wb_r     <= '0;
            write_register_r <= '0;
            misaligned_r     <= 1'b0;
            bus_err_r        <= 1'b0;
        end else begin
            valid_out_r      <= valid_in;
            wb_r             <= (valid_in && !fault_mis_s && !timeout_s) ? wb_in : '0;
            read_data_r      <= (done_s && !mem_write) ? load_s : '0;
            address_wb_r     <= address_in;
            write_register_r <= write_register_in;
            misaligned_r     <= fault_mis_s;
            bus_err_r        <= timeout_s;
        end
    end

    // Reset gates the request and stall directly so they fall without waiting for a clock.
    assign ram_req            = req_s & ~rst;
    assign stall              = stall_s & ~rst;
    assign ram_we             = mem_write;
    assign ram_adr            = {address_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    assign valid_out          = valid_out_r;
    assign wb                 = wb_r;
    assign read_data          = read_data_r;
    assign address_wb         = address_wb_r;
    assign write_register_out = write_register_r;
    assign misaligned         = misaligned_r;
    assign bus_err            = bus_err_r;

endmodule
